// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial N-bit subtractor z = a - b, LSB first, one bit/clock
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z,
    output logic         rout,
    output logic         ovf
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [CW-1:0] c_last = CW'(N - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_res;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_a_msb;
    logic          r_b_msb;
    logic [N-1:0]  r_z;
    logic          r_rout;
    logic          r_ovf;

    logic          w_nb;
    logic          w_p;
    logic          w_s;
    logic          w_c;
    logic [N-1:0]  w_res_next;
    logic          w_last;

    // One full-adder cell computing a + ~b + carry; carry is preset to 1.
    assign w_nb       = ~r_b_sh[0];
    assign w_p        = r_a_sh[0] ^ w_nb;
    assign w_s        = w_p ^ r_carry;
    assign w_c        = (r_a_sh[0] & w_nb) | (r_carry & w_p);
    assign w_res_next = {w_s, r_res[N-1:1]};
    assign w_last     = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_z     <= '0;
            r_rout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_a_msb <= a[N-1];
                        r_b_msb <= b[N-1];
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_run;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                c_run: begin
                    r_a_sh  <= {1'b0, r_a_sh[N-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[N-1:1]};
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        // The final sum bit is the result MSB, so overflow uses w_s directly.
                        r_z     <= w_res_next;
                        r_rout  <= ~w_c;
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_s != r_a_msb);
                        r_state <= c_done;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy = (r_state == c_run);
    assign done = (r_state == c_done);
    assign z    = r_z;
    assign rout = r_rout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, z = a - b, processed LSB-first, one bit per clock.
- A single full-adder cell plus a carry flip-flop do the work, using a + ~b + 1.
- This is the inverse-direction counterpart to the combinational full-adder path.
- Used where area matters more than latency; start/done handshake to the surrounding controller.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; one-cycle pulse, accepted only when not busy.
- a  input  N  minuend; sampled on the accepted-start edge only.
- b  input  N  subtrahend; sampled on the accepted-start edge only.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when z/rout/ovf become valid.
- z  output  N  difference a - b, modulo 2^N.
- rout  output  1  borrow out; 1 iff a < b unsigned.
- ovf  output  1  two's-complement overflow of a - b.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, z=0, rout=0, ovf=0.
  - Internal shift registers, bit counter and carry are cleared.
  - Reset overrides start and any operation in flight; a partial result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a and b into shift registers and sets carry=1.
  - It also clears the bit counter and moves to RUN.
  - start=0 stays in IDLE.
- RUN (busy=1), every cycle:
  - s = a_sh[0] ^ ~b_sh[0] ^ c.
  - c_next = (a_sh[0] & ~b_sh[0]) | (c & (a_sh[0] ^ ~b_sh[0])).
  - s is shifted into the result register from the MSB end; a_sh and b_sh shift right by one.
  - Counter increments; after the N-th bit cycle the next state is DONE.
  - start is ignored during RUN: no restart, no operand resample.
- Leaving RUN (on the edge that enters DONE):
  - z <= full result register.
  - rout <= ~c_final.
  - ovf <= (a[N-1] != b[N-1]) && (z[N-1] != a[N-1]), using the latched operand MSBs.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE, giving back-to-back operation.
  - Otherwise the next state is IDLE.
- Latency:
  - start accepted at edge t; busy=1 from t through t+N.
  - done=1 in the cycle following edge t+N.
  - Total N+1 cycles; throughput is one result per N+1 cycles.
- Hold: z, rout and ovf keep their last values through IDLE and through the next RUN. They change only on the edge that enters DONE, or on reset.
- Input stability: a and b may change freely after the start edge.
- Wrap-around: the result is always modulo 2^N. The unsigned borrow is flagged only via rout; the signed overflow is flagged only via ovf.

Test Plan (N=8):
- Basic subtraction: rst pulse, then start with a=0x05, b=0x03 -> done exactly 9 cycles after the start edge; z=0x02, rout=0, ovf=0; busy high for 8 cycles.
- Borrow: a=0x03, b=0x05 -> z=0xFE, rout=1, ovf=0.
- Signed overflow and edge values:
  - a=0x80, b=0x01 -> z=0x7F, rout=0, ovf=1.
  - a=0x00, b=0x00 -> z=0x00, rout=0, ovf=0.
  - a=0x00, b=0xFF -> z=0x01, rout=1, ovf=0.
- Start while busy:
  - Start a=0x10, b=0x01, then pulse start with a=0xFF, b=0xFF mid-RUN -> result z=0x0F, no second done.
  - Next, start asserted in the DONE cycle with a=0x20, b=0x30 -> second done 9 cycles later with z=0xF0, rout=1.
- Reset mid-operation: assert rst 4 cycles into RUN -> next cycle busy=0, done=0, z=0, rout=0, ovf=0; no done pulse follows; a fresh start then yields a correct result.
- Exhaustive sweep (N=4 build): all 256 (a,b) pairs -> z, rout and ovf match the reference model a-b mod 16, a<b, and signed overflow.
